// File: rtl/jbi_dbg_qctl_pkg.sv
// Shared debug-queue constants and read-FSM state encoding.
// Drop counters are built only when JBI_DBGQ_DROP_CNT_EN is defined.
package jbi_dbg_qctl_pkg;
  localparam int JBI_DBGQ_WIDTH      = 32;
  localparam int JBI_DBGQ_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } rd_state_e;
endpackage

// File: rtl/jbi_dbg_qptr.sv
// Per-queue pointers, occupancy, sticky overflow; write strobe same cycle as wr_vld.
// Writes are dropped when full; drop counter exists only with JBI_DBGQ_DROP_CNT_EN.
module jbi_dbg_qptr #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              wr_vld,
  input  logic              dbg_en,
  input  logic              ovf_clr,
  input  logic              rd_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic              empty,
  output logic              ovf,
  output logic [7:0]        drop_cnt
);
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] count;
  logic            full;
  logic            drop;

  // count never exceeds 2**ADDR_W, so the MSB alone marks full
  assign full  = count[ADDR_W];
  assign empty = (count == '0);
  assign wr_en = wr_vld & dbg_en & ~full;
  assign drop  = wr_vld & dbg_en & full;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef JBI_DBGQ_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      drop_cnt <= 8'd0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif
endmodule

// File: rtl/jbi_dbg_qctl.sv
// Debug queue control: write strobes, hi/lo read arbitration, single-entry output stage.
// Read-to-valid 2 cycles, one entry per 2 cycles; output held while ~dbg_out_rdy (JBI_DBGQ_DROP_CNT_EN optional).
module jbi_dbg_qctl
  import jbi_dbg_qctl_pkg::*;
#(
  parameter int DATA_W     = JBI_DBGQ_WIDTH,
  parameter int ADDR_W     = JBI_DBGQ_ADDR_WIDTH,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              csr_dbg_en,
  input  logic              csr_ovf_clr,
  input  logic              hi_wr_vld,
  input  logic [DATA_W-1:0] hi_wr_data,
  input  logic              lo_wr_vld,
  input  logic [DATA_W-1:0] lo_wr_data,
  output logic [ADDR_W-1:0] dbgq_hi_waddr,
  output logic              dbgq_hi_csn_wr,
  output logic [DATA_W-1:0] dbgq_hi_wdata,
  output logic [ADDR_W-1:0] dbgq_lo_waddr,
  output logic              dbgq_lo_csn_wr,
  output logic [DATA_W-1:0] dbgq_lo_wdata,
  output logic [ADDR_W-1:0] dbgq_hi_raddr,
  output logic              dbgq_hi_csn_rd,
  output logic [ADDR_W-1:0] dbgq_lo_raddr,
  output logic              dbgq_lo_csn_rd,
  input  logic [DATA_W-1:0] dbgq_hi_rdata,
  input  logic [DATA_W-1:0] dbgq_lo_rdata,
  output logic              dbg_out_vld,
  output logic              dbg_out_hi,
  output logic [DATA_W-1:0] dbg_out_data,
  input  logic              dbg_out_rdy,
  output logic              hi_ovf,
  output logic              lo_ovf,
  output logic [7:0]        hi_drop_cnt,
  output logic [7:0]        lo_drop_cnt
);
  localparam int            SW  = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  rd_state_e     state, state_nxt;
  logic          hi_wr_en, lo_wr_en, hi_empty, lo_empty;
  logic          hi_ne, lo_ne, grant_hi, hi_rd, lo_rd;
  logic          rd_issue, load_out, clr_vld, sel_hi_q;
  logic [SW-1:0] starve_cnt;

  jbi_dbg_qptr #(.ADDR_W(ADDR_W)) u_hi (
    .clk(clk), .rst_l(rst_l), .wr_vld(hi_wr_vld), .dbg_en(csr_dbg_en),
    .ovf_clr(csr_ovf_clr), .rd_en(hi_rd), .wr_en(hi_wr_en),
    .wptr(dbgq_hi_waddr), .rptr(dbgq_hi_raddr), .empty(hi_empty),
    .ovf(hi_ovf), .drop_cnt(hi_drop_cnt)
  );

  jbi_dbg_qptr #(.ADDR_W(ADDR_W)) u_lo (
    .clk(clk), .rst_l(rst_l), .wr_vld(lo_wr_vld), .dbg_en(csr_dbg_en),
    .ovf_clr(csr_ovf_clr), .rd_en(lo_rd), .wr_en(lo_wr_en),
    .wptr(dbgq_lo_waddr), .rptr(dbgq_lo_raddr), .empty(lo_empty),
    .ovf(lo_ovf), .drop_cnt(lo_drop_cnt)
  );

  assign dbgq_hi_csn_wr = ~hi_wr_en;
  assign dbgq_lo_csn_wr = ~lo_wr_en;
  assign dbgq_hi_wdata  = hi_wr_data;
  assign dbgq_lo_wdata  = lo_wr_data;

  // hi has priority; lo gets one forced slot after STARVE_LIM hi grants
  assign hi_ne    = ~hi_empty;
  assign lo_ne    = ~lo_empty;
  assign grant_hi = hi_ne & ~(lo_ne & (starve_cnt == LIM));
  assign hi_rd    = rd_issue & grant_hi;
  assign lo_rd    = rd_issue & ~grant_hi;
  assign dbgq_hi_csn_rd = ~hi_rd;
  assign dbgq_lo_csn_rd = ~lo_rd;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    load_out  = 1'b0;
    clr_vld   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hi_ne | lo_ne) begin
          rd_issue  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        load_out  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (dbg_out_rdy) begin
          clr_vld = 1'b1;
          if (hi_ne | lo_ne) begin
            rd_issue  = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      starve_cnt   <= '0;
      sel_hi_q     <= 1'b0;
      dbg_out_vld  <= 1'b0;
      dbg_out_hi   <= 1'b0;
      dbg_out_data <= '0;
    end else begin
      if (!lo_ne)        starve_cnt <= '0;
      else if (rd_issue) starve_cnt <= grant_hi ? starve_cnt + SW'(1) : '0;
      if (rd_issue) sel_hi_q <= grant_hi;
      if (load_out) begin
        dbg_out_vld  <= 1'b1;
        dbg_out_hi   <= sel_hi_q;
        dbg_out_data <= sel_hi_q ? dbgq_hi_rdata : dbgq_lo_rdata;
      end else if (clr_vld) begin
        dbg_out_vld  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jbi_dbg_qctl.sv
// Bench for jbi_dbg_qctl: queue-level reference model, RAM stub, directed scenarios.
module tb_jbi_dbg_qctl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SLIM = 4;
`ifdef JBI_DBGQ_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic clk = 1'b0, rst_l;
  logic csr_dbg_en, csr_ovf_clr, hi_wr_vld, lo_wr_vld, dbg_out_rdy;
  logic [DW-1:0] hi_wr_data, lo_wr_data, dbgq_hi_rdata, dbgq_lo_rdata;
  logic [AW-1:0] dbgq_hi_waddr, dbgq_lo_waddr, dbgq_hi_raddr, dbgq_lo_raddr;
  logic dbgq_hi_csn_wr, dbgq_lo_csn_wr, dbgq_hi_csn_rd, dbgq_lo_csn_rd;
  logic [DW-1:0] dbgq_hi_wdata, dbgq_lo_wdata, dbg_out_data;
  logic dbg_out_vld, dbg_out_hi, hi_ovf, lo_ovf;
  logic [7:0] hi_drop_cnt, lo_drop_cnt;

  jbi_dbg_qctl #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst_l(rst_l), .csr_dbg_en(csr_dbg_en), .csr_ovf_clr(csr_ovf_clr),
    .hi_wr_vld(hi_wr_vld), .hi_wr_data(hi_wr_data),
    .lo_wr_vld(lo_wr_vld), .lo_wr_data(lo_wr_data),
    .dbgq_hi_waddr(dbgq_hi_waddr), .dbgq_hi_csn_wr(dbgq_hi_csn_wr), .dbgq_hi_wdata(dbgq_hi_wdata),
    .dbgq_lo_waddr(dbgq_lo_waddr), .dbgq_lo_csn_wr(dbgq_lo_csn_wr), .dbgq_lo_wdata(dbgq_lo_wdata),
    .dbgq_hi_raddr(dbgq_hi_raddr), .dbgq_hi_csn_rd(dbgq_hi_csn_rd),
    .dbgq_lo_raddr(dbgq_lo_raddr), .dbgq_lo_csn_rd(dbgq_lo_csn_rd),
    .dbgq_hi_rdata(dbgq_hi_rdata), .dbgq_lo_rdata(dbgq_lo_rdata),
    .dbg_out_vld(dbg_out_vld), .dbg_out_hi(dbg_out_hi), .dbg_out_data(dbg_out_data),
    .dbg_out_rdy(dbg_out_rdy), .hi_ovf(hi_ovf), .lo_ovf(lo_ovf),
    .hi_drop_cnt(hi_drop_cnt), .lo_drop_cnt(lo_drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM stub: synchronous write, read data valid the cycle after the strobe
  logic [DW-1:0] hi_mem [32];
  logic [DW-1:0] lo_mem [32];
  always @(posedge clk) begin
    if (!dbgq_hi_csn_wr) hi_mem[dbgq_hi_waddr] <= dbgq_hi_wdata;
    if (!dbgq_lo_csn_wr) lo_mem[dbgq_lo_waddr] <= dbgq_lo_wdata;
    if (!dbgq_hi_csn_rd) dbgq_hi_rdata <= hi_mem[dbgq_hi_raddr];
    if (!dbgq_lo_csn_rd) dbgq_lo_rdata <= lo_mem[dbgq_lo_raddr];
  end

  int vectors = 0, errors = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: two FIFOs plus an output slot that is one read behind
  logic [DW-1:0] mq_hi[$], mq_lo[$];
  int m_hw = 0, m_hr = 0, m_lw = 0, m_lr = 0, m_starve = 0, m_hcnt = 0, m_lcnt = 0;
  bit m_vld = 0, m_hi = 0, m_fetch = 0, m_fhi = 0, m_hovf = 0, m_lovf = 0;
  logic [DW-1:0] m_data = '0, m_fdata = '0;

  function automatic void predict(output bit hwe, output bit lwe, output bit hdrop,
                                  output bit ldrop, output bit iss, output bit ghi);
    hwe   = hi_wr_vld && csr_dbg_en && mq_hi.size() < 32;
    lwe   = lo_wr_vld && csr_dbg_en && mq_lo.size() < 32;
    hdrop = hi_wr_vld && csr_dbg_en && mq_hi.size() == 32;
    ldrop = lo_wr_vld && csr_dbg_en && mq_lo.size() == 32;
    iss   = !m_fetch && (!m_vld || dbg_out_rdy) && (mq_hi.size() > 0 || mq_lo.size() > 0);
    ghi   = mq_hi.size() > 0 && !(mq_lo.size() > 0 && m_starve == SLIM);
  endfunction

  always @(posedge clk or negedge rst_l) begin
    bit hwe, lwe, hdrop, ldrop, iss, ghi, lo_ne;
    if (!rst_l) begin
      mq_hi.delete(); mq_lo.delete();
      m_hw = 0; m_hr = 0; m_lw = 0; m_lr = 0; m_starve = 0; m_hcnt = 0; m_lcnt = 0;
      m_vld = 0; m_hi = 0; m_fetch = 0; m_fhi = 0; m_hovf = 0; m_lovf = 0;
      m_data = '0; m_fdata = '0;
    end else begin
      cyc++;
      predict(hwe, lwe, hdrop, ldrop, iss, ghi);
      lo_ne = mq_lo.size() > 0;
      if (m_fetch) begin
        m_vld = 1; m_hi = m_fhi; m_data = m_fdata; m_fetch = 0;
      end else if (m_vld && dbg_out_rdy) begin
        m_vld = 0;
      end
      if (!lo_ne) m_starve = 0;
      else if (iss) m_starve = ghi ? m_starve + 1 : 0;
      if (iss) begin
        m_fetch = 1; m_fhi = ghi;
        if (ghi) begin m_fdata = mq_hi.pop_front(); m_hr = (m_hr + 1) % 32; end
        else     begin m_fdata = mq_lo.pop_front(); m_lr = (m_lr + 1) % 32; end
      end
      if (hwe) begin mq_hi.push_back(hi_wr_data); m_hw = (m_hw + 1) % 32; end
      if (lwe) begin mq_lo.push_back(lo_wr_data); m_lw = (m_lw + 1) % 32; end
      if (hdrop) m_hovf = 1; else if (csr_ovf_clr) m_hovf = 0;
      if (ldrop) m_lovf = 1; else if (csr_ovf_clr) m_lovf = 0;
      if (DROP_EN != 0) begin
        if (csr_ovf_clr) m_hcnt = hdrop ? 1 : 0; else if (hdrop && m_hcnt < 255) m_hcnt++;
        if (csr_ovf_clr) m_lcnt = ldrop ? 1 : 0; else if (ldrop && m_lcnt < 255) m_lcnt++;
      end
    end
  end

  // Per-cycle compare plus logs for the literal checks
  logic [DW:0] out_log[$];
  int out_cyc[$];
  int wa_log[$];

  always @(negedge clk) begin
    bit hwe, lwe, hdrop, ldrop, iss, ghi;
    predict(hwe, lwe, hdrop, ldrop, iss, ghi);
    if (!rst_l) begin
      hwe = 0; lwe = 0; iss = 0;
    end
    check("hi_csn_wr", dbgq_hi_csn_wr, !hwe);
    check("lo_csn_wr", dbgq_lo_csn_wr, !lwe);
    if (hwe) check("hi_waddr", dbgq_hi_waddr, m_hw);
    if (lwe) check("lo_waddr", dbgq_lo_waddr, m_lw);
    check("hi_csn_rd", dbgq_hi_csn_rd, !(iss && ghi));
    check("lo_csn_rd", dbgq_lo_csn_rd, !(iss && !ghi));
    if (iss && ghi)  check("hi_raddr", dbgq_hi_raddr, m_hr);
    if (iss && !ghi) check("lo_raddr", dbgq_lo_raddr, m_lr);
    check("out_vld", dbg_out_vld, m_vld);
    if (m_vld) begin
      check("out_hi", dbg_out_hi, m_hi);
      check("out_data", dbg_out_data, m_data);
    end
    check("hi_ovf", hi_ovf, m_hovf);
    check("lo_ovf", lo_ovf, m_lovf);
    check("hi_drop_cnt", hi_drop_cnt, m_hcnt);
    check("lo_drop_cnt", lo_drop_cnt, m_lcnt);
    if (dbg_out_vld && dbg_out_rdy) begin
      out_log.push_back({dbg_out_hi, dbg_out_data});
      out_cyc.push_back(cyc);
    end
    if (!dbgq_hi_csn_wr) wa_log.push_back(int'(dbgq_hi_waddr));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_log.size() < n; i++) tick();
    check("drain_count", out_log.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] pat;
    int k;
    rst_l = 0; csr_dbg_en = 1; csr_ovf_clr = 0; dbg_out_rdy = 1;
    hi_wr_vld = 0; lo_wr_vld = 0; hi_wr_data = '0; lo_wr_data = '0;
    repeat (3) tick();
    check("rst_vld", dbg_out_vld, 0);
    check("rst_csn_rd", dbgq_hi_csn_rd, 1);
    rst_l = 1;
    tick();

    // three hi entries, rdy high
    out_log.delete(); out_cyc.delete(); wa_log.delete();
    for (int i = 0; i < 3; i++) begin
      hi_wr_vld = 1; hi_wr_data = DW'(32'hA0 + i); tick();
    end
    hi_wr_vld = 0;
    wait_out(3, 50);
    for (int i = 0; i < 3 && i < out_log.size(); i++)
      check("t1_entry", out_log[i], {1'b1, DW'(32'hA0 + i)});
    for (int i = 1; i < 3 && i < out_cyc.size(); i++)
      check("t1_spacing", out_cyc[i] - out_cyc[i-1], 2);
    for (int i = 0; i < 3 && i < wa_log.size(); i++)
      check("t1_waddr", wa_log[i], i);
    repeat (4) tick();

    // lo fill with rdy low: 33 stored (one in the output slot), rest dropped
    dbg_out_rdy = 0; out_log.delete();
    for (int i = 0; i < 334; i++) begin
      lo_wr_vld = 1; lo_wr_data = DW'(32'h100 + i); tick();
    end
    lo_wr_vld = 0;
    check("t2_lo_ovf", lo_ovf, 1);
    check("t2_drop_sat", lo_drop_cnt, DROP_EN != 0 ? 255 : 0);
    csr_ovf_clr = 1; tick(); csr_ovf_clr = 0;
    check("t2_ovf_clr", lo_ovf, 0);
    check("t2_cnt_clr", lo_drop_cnt, 0);
    lo_wr_vld = 1; csr_ovf_clr = 1; tick(); lo_wr_vld = 0; csr_ovf_clr = 0;
    check("t2_drop_wins", lo_ovf, 1);
    check("t2_drop_in_clr", lo_drop_cnt, DROP_EN != 0 ? 1 : 0);
    csr_ovf_clr = 1; tick(); csr_ovf_clr = 0;
    repeat (20) tick();
    check("t2_hold_vld", dbg_out_vld, 1);
    check("t2_hold_data", dbg_out_data, 32'h100);
    check("t2_hold_hi", dbg_out_hi, 0);
    dbg_out_rdy = 1;
    wait_out(33, 200);
    for (int i = 0; i < 33 && i < out_log.size(); i++)
      check("t2_order", out_log[i], {1'b0, DW'(32'h100 + i)});
    repeat (4) tick();

    // arbitration: 10 hi and 10 lo written together
    out_log.delete();
    for (int i = 0; i < 10; i++) begin
      hi_wr_vld = 1; hi_wr_data = DW'(32'h200 + i);
      lo_wr_vld = 1; lo_wr_data = DW'(32'h300 + i); tick();
    end
    hi_wr_vld = 0; lo_wr_vld = 0;
    wait_out(20, 200);
    pat = 20'b1111_0_1111_0_11_00000000;
    k = 0;
    for (int i = 0; i < 20 && i < out_log.size(); i++) begin
      check("t3_grant", out_log[i][DW], pat[19-i]);
      if (!out_log[i][DW]) begin
        check("t3_lo_order", out_log[i][DW-1:0], 32'h300 + k); k++;
      end
    end
    repeat (4) tick();

    // pointer wrap with interleaved writes and reads
    out_log.delete();
    for (int i = 0; i < 40; i++) begin
      hi_wr_vld = 1; hi_wr_data = DW'(32'h400 + i); tick(); hi_wr_vld = 0; tick();
      lo_wr_vld = 1; lo_wr_data = DW'(32'h500 + i); tick(); lo_wr_vld = 0; tick();
    end
    wait_out(80, 200);
    begin
      int nh = 0, nl = 0;
      foreach (out_log[i]) begin
        if (out_log[i][DW]) begin check("t4_hi_order", out_log[i][DW-1:0], 32'h400 + nh); nh++; end
        else                begin check("t4_lo_order", out_log[i][DW-1:0], 32'h500 + nl); nl++; end
      end
      check("t4_hi_total", nh, 40);
    end
    repeat (4) tick();

    // async reset mid-HOLD with 5 entries still queued
    dbg_out_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      hi_wr_vld = 1; hi_wr_data = DW'(32'h600 + i); tick();
    end
    hi_wr_vld = 0;
    repeat (3) tick();
    check("t5_pre_vld", dbg_out_vld, 1);
    #2 rst_l = 0;
    #1 check("t5_async_vld", dbg_out_vld, 0);
    check("t5_async_data", dbg_out_data, 0);
    tick(); tick();
    rst_l = 1; dbg_out_rdy = 1; out_log.delete();
    repeat (10) tick();
    check("t5_no_output", out_log.size(), 0);
    check("t5_no_rd", dbgq_hi_csn_rd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
